// File: rtl/uart_pkg.sv
// Shared constants and types for the memory-mapped UART transmitter.
package uart_pkg;

   // Register byte offsets inside the peripheral window (only bit 2 is decoded)
   localparam logic [3:0] UART_DATA   = 4'h0;
   localparam logic [3:0] UART_STATUS = 4'h4;

   // STATUS word bit positions
   localparam int STAT_BUSY      = 0;
   localparam int STAT_FULL      = 1;
   localparam int STAT_EMPTY     = 2;
   localparam int STAT_OVERFLOW  = 3;
   localparam int STAT_COUNT_LSB = 4;
   localparam int STAT_COUNT_W   = 4;

   // Serializer state encoding
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } tx_state_e;

endpackage

// File: rtl/byte_fifo.sv
// Synchronous byte FIFO with a combinational head output. A push while full is
// still accepted when a pop happens on the same edge, since a slot frees up.
module byte_fifo #(
   parameter int  DEPTH = 4,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [7:0]       din,
   input  logic             pop,
   output logic [7:0]       dout,
   output logic [CNT_W-1:0] count,
   output logic             full,
   output logic             empty
);

   logic [7:0]       mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_push;
   logic             do_pop;

   assign full  = (count_q == CNT_W'(DEPTH));
   assign empty = (count_q == '0);
   assign count = count_q;
   assign dout  = mem[rd_ptr_q];

   // Next-state for pointers and occupancy; pointers wrap naturally at DEPTH
   always_comb begin
      // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and a latch is never inferred.
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      do_pop   = pop && !empty;
      do_push  = push && (!full || do_pop);
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (do_push && !do_pop)      count_d = count_q + 1'b1;
      else if (!do_push && do_pop) count_d = count_q - 1'b1;
   end

   // Control state registers with synchronous reset
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values regardless of statement order.
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage array; contents are only meaningful behind a valid count
   always_ff @(posedge clk) begin
      // NOTE: the storage itself is not reset; count and pointers gate every read, so resetting it would only cost logic.
      if (do_push) mem[wr_ptr_q] <= din;
   end

endmodule

// File: rtl/uart_tx_port.sv
// Memory-mapped 8N1 UART transmitter: bus decode, STATUS/read-data register,
// sticky overflow flag and the bit serializer in front of a byte FIFO.
module uart_tx_port
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 4,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        sel,
   input  logic [3:0]  addr,
   input  logic        ren,
   input  logic        wen,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        txd
);

   localparam int BAUD_W = $clog2(CLKS_PER_BIT);
   localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

   tx_state_e         state_q, state_d;
   logic [BAUD_W-1:0] baud_q, baud_d;
   logic [2:0]        bit_idx_q, bit_idx_d;
   logic [7:0]        shift_q, shift_d;
   logic              txd_q, txd_d;
   logic [31:0]       rdata_q, rdata_d;
   logic              ovf_q, ovf_d;

   logic              push_req;
   logic              status_rd;
   logic              data_rd;
   logic              baud_last;
   logic              fifo_pop;
   logic [7:0]        fifo_dout;
   logic [CNT_W-1:0]  fifo_count;
   logic              fifo_full;
   logic              fifo_empty;
   logic [31:0]       status_word;
   logic              unused_bus_bits;

   assign unused_bus_bits = ^{addr[3], addr[1:0], wdata[31:8]};

   assign push_req  = sel && wen && (addr[2] == UART_DATA[2]);
   assign status_rd = sel && ren && (addr[2] == UART_STATUS[2]);
   assign data_rd   = sel && ren && (addr[2] == UART_DATA[2]);
   assign baud_last = (baud_q == BAUD_LAST);

   byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push_req),
      .din   (wdata[7:0]),
      .pop   (fifo_pop),
      .dout  (fifo_dout),
      .count (fifo_count),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // Serializer next-state: start bit, 8 data bits LSB first, stop bit
   always_comb begin
      state_d   = state_q;
      baud_d    = baud_q;
      bit_idx_d = bit_idx_q;
      shift_d   = shift_q;
      txd_d     = txd_q;
      fifo_pop  = 1'b0;
      unique case (state_q)
         IDLE: begin
            baud_d = '0;
            txd_d  = 1'b1;
            if (!fifo_empty) begin
               fifo_pop = 1'b1;
               shift_d  = fifo_dout;
               txd_d    = 1'b0;
               state_d  = START;
            end
         end
         START: begin
            if (baud_last) begin
               baud_d    = '0;
               txd_d     = shift_q[0];
               bit_idx_d = '0;
               state_d   = DATA;
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end
         DATA: begin
            if (baud_last) begin
               baud_d = '0;
               if (bit_idx_q == 3'd7) begin
                  txd_d   = 1'b1;
                  state_d = STOP;
               end else begin
                  shift_d   = {1'b0, shift_q[7:1]};
                  txd_d     = shift_q[1];
                  bit_idx_d = bit_idx_q + 1'b1;
               end
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end
         STOP: begin
            if (baud_last) begin
               baud_d = '0;
               if (!fifo_empty) begin
                  // Back-to-back frame: reload straight into a start bit
                  fifo_pop = 1'b1;
                  shift_d  = fifo_dout;
                  txd_d    = 1'b0;
                  state_d  = START;
               end else begin
                  txd_d   = 1'b1;
                  state_d = IDLE;
               end
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // STATUS assembly, sticky overflow (set beats clear) and read-data capture
   always_comb begin
      status_word                                    = '0;
      status_word[STAT_BUSY]                         = (state_q != IDLE);
      status_word[STAT_FULL]                         = fifo_full;
      status_word[STAT_EMPTY]                        = fifo_empty;
      status_word[STAT_OVERFLOW]                     = ovf_q;
      status_word[STAT_COUNT_LSB +: STAT_COUNT_W]    = STAT_COUNT_W'(fifo_count);

      ovf_d = ovf_q;
      if (status_rd) ovf_d = 1'b0;
      if (push_req && fifo_full && !fifo_pop) ovf_d = 1'b1;

      rdata_d = rdata_q;
      if (status_rd)    rdata_d = status_word;
      else if (data_rd) rdata_d = '0;
   end

   // All serializer and bus-facing registers, synchronous active-high reset
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         baud_q    <= '0;
         bit_idx_q <= '0;
         shift_q   <= '0;
         txd_q     <= 1'b1;
         rdata_q   <= '0;
         ovf_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         baud_q    <= baud_d;
         bit_idx_q <= bit_idx_d;
         shift_q   <= shift_d;
         txd_q     <= txd_d;
         rdata_q   <= rdata_d;
         ovf_q     <= ovf_d;
      end
   end

   assign txd   = txd_q;
   assign rdata = rdata_q;

endmodule

// File: tb/tb_uart_tx_port.sv
// Directed self-checking bench for uart_tx_port (CLKS_PER_BIT=4, FIFO_DEPTH=4).
module tb_uart_tx_port;

   logic        clk;
   logic        reset;
   logic        sel;
   logic [3:0]  addr;
   logic        ren;
   logic        wen;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        txd;

   int checks;
   int errors;

   // Frames decoded by the line monitor: {stop_bit, data_byte}
   logic [8:0] frame_q [$];

   uart_tx_port #(.CLKS_PER_BIT(4), .FIFO_DEPTH(4)) dut (
      .clk   (clk),
      .reset (reset),
      .sel   (sel),
      .addr  (addr),
      .ren   (ren),
      .wen   (wen),
      .wdata (wdata),
      .rdata (rdata),
      .txd   (txd)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Line monitor: detects a start bit and samples each bit mid-cell
   initial begin
      logic [8:0] fr;
      forever begin
         @(negedge clk);
         if (txd === 1'b0) begin
            repeat (2) @(negedge clk);
            for (int i = 0; i < 8; i++) begin
               repeat (4) @(negedge clk);
               fr[i] = txd;
            end
            repeat (4) @(negedge clk);
            fr[8] = txd;
            frame_q.push_back(fr);
         end
      end
   end

   // Bus tasks: called at a negedge, the following posedge is the access edge
   task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
      sel = 1'b1; wen = 1'b1; addr = a; wdata = d;
      @(negedge clk);
      sel = 1'b0; wen = 1'b0; wdata = '0;
   endtask

   task automatic bus_read(input logic [3:0] a);
      sel = 1'b1; ren = 1'b1; addr = a;
      @(negedge clk);
      sel = 1'b0; ren = 1'b0;
   endtask

   task automatic apply_reset();
      @(negedge clk);
      reset = 1'b1; sel = 1'b0; ren = 1'b0; wen = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      repeat (45) @(negedge clk);
      frame_q.delete();
   endtask

   task automatic test_reset();
      reset = 1'b1; sel = 1'b0; ren = 1'b0; wen = 1'b0; addr = '0; wdata = '0;
      repeat (3) @(negedge clk);
      checks++;
      if (txd !== 1'b1) begin errors++; $display("FAIL reset_txd: got %b expected 1", txd); end
      checks++;
      if (rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h expected 00000000", rdata); end
      reset = 1'b0;
      @(negedge clk);
      bus_read(4'h4);
      checks++;
      if (rdata !== 32'h0000_0004) begin errors++; $display("FAIL reset_status: got %h expected 00000004", rdata); end
      checks++;
      if (txd !== 1'b1) begin errors++; $display("FAIL reset_txd_idle: got %b expected 1", txd); end
   endtask

   task automatic test_single_frame();
      logic [0:9] pat;
      logic       bad;
      logic       got;
      apply_reset();
      pat = 10'b0_10101010_1;  // 0x55: start, d0..d7, stop
      bus_write(4'h0, 32'hFFFF_FF55);
      for (int c = 0; c < 10; c++) begin
         bad = 1'b0; got = 1'b0;
         for (int s = 0; s < 4; s++) begin
            @(negedge clk);
            if (txd !== pat[c]) begin bad = 1'b1; got = txd; end
         end
         checks++;
         if (bad) begin errors++; $display("FAIL frame55_bit%0d: got %b expected %b", c, got, pat[c]); end
      end
      @(negedge clk);
      checks++;
      if (txd !== 1'b1) begin errors++; $display("FAIL frame55_idle: got %b expected 1", txd); end
      bus_read(4'h4);
      checks++;
      if (rdata !== 32'h0000_0004) begin errors++; $display("FAIL frame55_status: got %h expected 00000004", rdata); end
      bus_read(4'h0);
      checks++;
      if (rdata !== 32'h0) begin errors++; $display("FAIL data_read: got %h expected 00000000", rdata); end
   endtask

   task automatic test_back_to_back();
      logic [0:19] pat;
      logic        bad;
      logic        got;
      apply_reset();
      pat = 20'b0_11000101_1_0_11110000_1;  // 0xA3 then 0x0F
      bus_write(4'h0, 32'h0000_00A3);
      bus_write(4'h0, 32'h0000_000F);
      // First frame began at the edge after the first write; skip 1 cycle of it already elapsed
      for (int c = 0; c < 20; c++) begin
         bad = 1'b0; got = 1'b0;
         for (int s = 0; s < 4; s++) begin
            if (!(c == 0 && s == 0)) @(negedge clk);
            if (txd !== pat[c]) begin bad = 1'b1; got = txd; end
         end
         checks++;
         if (bad) begin errors++; $display("FAIL b2b_bit%0d: got %b expected %b", c, got, pat[c]); end
      end
      @(negedge clk);
      checks++;
      if (txd !== 1'b1) begin errors++; $display("FAIL b2b_idle: got %b expected 1", txd); end
   endtask

   task automatic test_overflow();
      logic [8:0] exp_fr [5];
      apply_reset();
      exp_fr = '{9'h111, 9'h122, 9'h133, 9'h144, 9'h155};
      for (int i = 1; i <= 6; i++) bus_write(4'h0, 32'(i * 8'h11));
      // First byte is already in flight, so busy is set alongside count=4, full, overflow
      bus_read(4'h4);
      checks++;
      if (rdata !== 32'h0000_004B) begin errors++; $display("FAIL ovf_status: got %h expected 0000004B", rdata); end
      bus_read(4'h4);
      checks++;
      if (rdata !== 32'h0000_0043) begin errors++; $display("FAIL ovf_cleared: got %h expected 00000043", rdata); end
      repeat (210) @(negedge clk);
      checks++;
      if (frame_q.size() !== 5) begin errors++; $display("FAIL ovf_frame_count: got %0d expected 5", frame_q.size()); end
      for (int i = 0; i < 5; i++) begin
         if (i < frame_q.size()) begin
            checks++;
            if (frame_q[i] !== exp_fr[i]) begin errors++; $display("FAIL ovf_frame%0d: got %h expected %h", i, frame_q[i], exp_fr[i]); end
         end
      end
      bus_read(4'h4);
      checks++;
      if (rdata !== 32'h0000_0004) begin errors++; $display("FAIL ovf_drained: got %h expected 00000004", rdata); end
   endtask

   task automatic test_push_on_pop_when_full();
      apply_reset();
      for (int i = 0; i < 5; i++) bus_write(4'h0, 32'(8'hA0 + i));
      // First frame starts at write0 edge +1 and its stop ends 40 edges later
      repeat (36) @(negedge clk);
      bus_write(4'h0, 32'h0000_00B5);
      checks++;
      if (txd !== 1'b0) begin errors++; $display("FAIL fullpop_start: got %b expected 0", txd); end
      bus_read(4'h4);
      checks++;
      if (rdata !== 32'h0000_0043) begin errors++; $display("FAIL fullpop_status: got %h expected 00000043", rdata); end
      repeat (210) @(negedge clk);
      checks++;
      if (frame_q.size() !== 6) begin errors++; $display("FAIL fullpop_frames: got %0d expected 6", frame_q.size()); end
      else begin
         checks++;
         if (frame_q[5] !== 9'h1B5) begin errors++; $display("FAIL fullpop_last: got %h expected 1B5", frame_q[5]); end
      end
   endtask

   task automatic test_reset_mid_frame();
      int lows;
      apply_reset();
      bus_read(4'h4);
      bus_write(4'h0, 32'h0000_003C);
      bus_write(4'h0, 32'h0000_0081);
      // Now mid data bit 3 of the first frame
      repeat (16) @(negedge clk);
      checks++;
      if (txd !== 1'b1) begin errors++; $display("FAIL midrst_bit3: got %b expected 1", txd); end
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      checks++;
      if (txd !== 1'b1) begin errors++; $display("FAIL midrst_txd: got %b expected 1", txd); end
      checks++;
      if (rdata !== 32'h0) begin errors++; $display("FAIL midrst_rdata: got %h expected 00000000", rdata); end
      lows = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (txd !== 1'b1) lows++;
      end
      checks++;
      if (lows != 0) begin errors++; $display("FAIL midrst_quiet: got %0d low cycles expected 0", lows); end
      bus_read(4'h4);
      checks++;
      if (rdata !== 32'h0000_0004) begin errors++; $display("FAIL midrst_status: got %h expected 00000004", rdata); end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_single_frame();
      test_back_to_back();
      test_overflow();
      test_push_on_pop_when_full();
      test_reset_mid_frame();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
